// File: rtl/training_sequencer.sv
// -----------------------------------------------------------------------------
// training_sequencer
//
// Sequences a training run for learningNeuron. Each run is `epochs` passes of
// `samples` samples. For each sample the block:
//   1. accepts one vector and target from the sample source,
//   2. waits SETTLE cycles so the neuron output can settle,
//   3. pulses learn_en for one cycle so the weights update,
//   4. advances the sample and epoch counters.
// A run ends with a one-cycle done pulse.
//
// Per-sample latency is 1 (FETCH) + SETTLE + 1 (LEARN) + 1 (ADVANCE) cycles.
// SETTLE is expected to be at least 1.
//
// Optional feature (macro TRAINING_SEQUENCER_ERR_ACCUM_EN):
//   Adds output err_sum. It accumulates |target - neuron_out| (signed) once
//   per LEARN cycle, restarts with each epoch's first sample, and saturates at
//   its maximum value. While done is high it holds the last epoch's total.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   start              one-cycle pulse; ignored while busy
//   epochs, samples    run configuration, sampled on start
//   s_valid/s_ready    sample-source handshake
//   s_data, s_target   sample vector and expected output
//   neuron_in, target  registered sample and target driven to the neuron
//   learn_en           one-cycle weight-update strobe
//   neuron_out         neuron output (used only by the error accumulator)
//   busy, done         status; busy is high in every state except IDLE
//   epoch_cnt          completed epochs; holds after done until the next start
//   err_sum            (optional) per-epoch absolute-error total
// -----------------------------------------------------------------------------
module training_sequencer #(
  parameter int N_IN    = 32,
  parameter int W       = 32,
  parameter int SETTLE  = 10,
  parameter int EPOCH_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EPOCH_W-1:0]   epochs,
  input  logic [7:0]           samples,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N_IN*W-1:0]    s_data,
  input  logic [W-1:0]         s_target,
  output logic [N_IN*W-1:0]    neuron_in,
  output logic [W-1:0]         target,
  output logic                 learn_en,
  input  logic [W-1:0]         neuron_out,
  output logic                 busy,
  output logic                 done,
  output logic [EPOCH_W-1:0]   epoch_cnt
`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
  ,
  output logic [W+7:0]         err_sum
`endif
);

  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_LEARN,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  state_t               state, state_nx;

  logic [EPOCH_W-1:0]   epochs_q;
  logic [7:0]           samples_q;
  logic [7:0]           sample_cnt;
  logic [SCNT_W-1:0]    settle_cnt;

  logic                 start_ok;
  logic                 cfg_zero;
  logic                 xfer;
  logic                 settle_last;
  logic                 sample_last;
  logic [EPOCH_W-1:0]   epoch_inc;
  logic                 run_last;

  assign start_ok    = (state == ST_IDLE) && start;
  assign cfg_zero    = (epochs == '0) || (samples == 8'd0);
  assign xfer        = s_valid && s_ready;
  assign settle_last = (settle_cnt == SCNT_W'(SETTLE - 1));
  assign sample_last = (sample_cnt == samples_q - 8'd1);
  assign epoch_inc   = epoch_cnt + EPOCH_W'(1);
  assign run_last    = sample_last && (epoch_inc == epochs_q);

  // ---------------------------------------------------------------------------
  // State register. The asynchronous reset forces IDLE immediately, which also
  // drops every state-decoded output (learn_en included) without waiting for
  // a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block ordering.
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_nx unassigned and no latch is inferred.
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = cfg_zero ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // No timeout: the sequencer waits for the source as long as it takes.
        if (s_valid) begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_last) begin
          state_nx = ST_LEARN;
        end
      end
      ST_LEARN: begin
        state_nx = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        state_nx = run_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register.
  assign busy     = (state != ST_IDLE);
  assign s_ready  = (state == ST_FETCH);
  assign learn_en = (state == ST_LEARN);
  assign done     = (state == ST_DONE);

  // ---------------------------------------------------------------------------
  // Configuration, counters and the sample/target registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide data registers are reset as well because neuron_in and
      // target must read 0 during reset; they are plain flops, not a memory.
      epochs_q   <= '0;
      samples_q  <= '0;
      sample_cnt <= '0;
      settle_cnt <= '0;
      epoch_cnt  <= '0;
      neuron_in  <= '0;
      target     <= '0;
    end else begin
      if (start_ok) begin
        // A zero configuration still clears epoch_cnt, so the done pulse
        // reports zero completed epochs.
        epochs_q   <= epochs;
        samples_q  <= samples;
        sample_cnt <= '0;
        epoch_cnt  <= '0;
      end

      if (xfer) begin
        neuron_in  <= s_data;
        target     <= s_target;
        settle_cnt <= '0;
      end

      if (state == ST_SETTLE && !settle_last) begin
        settle_cnt <= settle_cnt + SCNT_W'(1);
      end

      if (state == ST_ADVANCE) begin
        if (sample_last) begin
          sample_cnt <= '0;
          epoch_cnt  <= epoch_inc;
        end else begin
          sample_cnt <= sample_cnt + 8'd1;
        end
      end
    end
  end

`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
  // ---------------------------------------------------------------------------
  // Per-epoch absolute-error accumulator. The difference is formed one bit
  // wider than W so the signed subtraction cannot overflow; its magnitude
  // then fits in W+1 unsigned bits (including the 2^W corner case).
  // The total restarts on the first LEARN of each epoch rather than at the
  // epoch boundary, so the completed epoch's total is still visible at done.
  // ---------------------------------------------------------------------------
  logic signed [W:0] err_diff;
  logic        [W:0] err_abs;
  logic        [W+8:0] err_add;

  assign err_diff = $signed({target[W-1], target}) - $signed({neuron_out[W-1], neuron_out});
  assign err_abs  = err_diff[W] ? (~err_diff + 1'b1) : err_diff;
  assign err_add  = {1'b0, err_sum} + (W+9)'(err_abs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum <= '0;
    end else if (start_ok) begin
      err_sum <= '0;
    end else if (state == ST_LEARN) begin
      if (sample_cnt == 8'd0) begin
        err_sum <= (W+8)'(err_abs);
      end else if (err_add[W+8]) begin
        err_sum <= '1;
      end else begin
        err_sum <= err_add[W+7:0];
      end
    end
  end
`else
  // neuron_out feeds only the optional error accumulator.
  logic unused_neuron_out;
  assign unused_neuron_out = ^neuron_out;
`endif

endmodule

// File: tb/tb_training_sequencer.sv
// -----------------------------------------------------------------------------
// tb_training_sequencer
//
// Directed bench for training_sequencer (N_IN=4, W=16, SETTLE=10). Inputs are
// driven 1 ns after the rising edge; a monitor samples outputs on the falling
// edge and records learn_en pulses, done pulses and s_ready cycles by cycle
// number. Expected values are hand-computed from the block's timing:
// start in cycle k -> FETCH at k+1, LEARN at k+12, one sample every 13 cycles,
// done at k + 13*n_samples_total + 1.
// -----------------------------------------------------------------------------
module tb_training_sequencer;

  localparam int N_IN    = 4;
  localparam int W       = 16;
  localparam int SETTLE  = 10;
  localparam int EPOCH_W = 16;

  localparam logic [N_IN*W-1:0] DATA_A = 64'h1111_2222_3333_4444;
  localparam logic [N_IN*W-1:0] DATA_B = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [W-1:0]      TGT_A  = 16'h0123;
  localparam logic [W-1:0]      TGT_B  = 16'h7ABC;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [EPOCH_W-1:0]   epochs;
  logic [7:0]           samples;
  logic                 s_valid;
  logic                 s_ready;
  logic [N_IN*W-1:0]    s_data;
  logic [W-1:0]         s_target;
  logic [N_IN*W-1:0]    neuron_in;
  logic [W-1:0]         target;
  logic                 learn_en;
  logic [W-1:0]         neuron_out;
  logic                 busy;
  logic                 done;
  logic [EPOCH_W-1:0]   epoch_cnt;
`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
  logic [W+7:0]         err_sum;
  logic [W+7:0]         err_at_done;
`endif

  training_sequencer #(
    .N_IN   (N_IN),
    .W      (W),
    .SETTLE (SETTLE),
    .EPOCH_W(EPOCH_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .epochs     (epochs),
    .samples    (samples),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_target   (s_target),
    .neuron_in  (neuron_in),
    .target     (target),
    .learn_en   (learn_en),
    .neuron_out (neuron_out),
    .busy       (busy),
    .done       (done),
    .epoch_cnt  (epoch_cnt)
`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
    ,
    .err_sum    (err_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: count of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: falling-edge sampling of the event outputs.
  int learn_q[$];
  int n_done   = 0;
  int done_cyc = 0;
  int n_ready  = 0;

  always @(negedge clk) begin
    if (learn_en) learn_q.push_back(cyc);
    if (s_ready) n_ready++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
      err_at_done = err_sum;
`endif
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_start(input logic [EPOCH_W-1:0] ep, input logic [7:0] sm);
    @(posedge clk); #1;
    epochs    = ep;
    samples   = sm;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = n_done;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done != base) break;
    end
    check(tag, 64'(n_done != base), 64'd1);
  endtask

  // Watchdog: the directed sequence needs well under a thousand cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lbase;
    int nl;
    int dbase;
    int rbase;

    rst_n      = 1'b0;
    start      = 1'b0;
    epochs     = '0;
    samples    = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_target   = '0;
    neuron_out = '0;

    // ---- Reset state --------------------------------------------------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_s_ready",   64'(s_ready),   64'd0);
    check("rst_learn_en",  64'(learn_en),  64'd0);
    check("rst_neuron_in", 64'(neuron_in), 64'd0);
    check("rst_target",    64'(target),    64'd0);
    check("rst_epoch_cnt", 64'(epoch_cnt), 64'd0);
    rst_n = 1'b1;

    // ---- Normal run: 2 epochs x 3 samples, source always valid --------------
    s_valid  = 1'b1;
    s_data   = DATA_A;
    s_target = TGT_A;
    lbase = learn_q.size();
    do_start(16'd2, 8'd3);
    @(negedge clk);
    check("run_busy", 64'(busy), 64'd1);
    wait_done("run_done_seen", 200);
    nl = learn_q.size() - lbase;
    check("run_learn_count", 64'(nl), 64'd6);
    if (nl > 0) check("run_first_learn", 64'(learn_q[lbase] - start_cyc), 64'd12);
    for (int i = 1; i < nl; i++)
      check($sformatf("run_learn_gap%0d", i), 64'(learn_q[lbase+i] - learn_q[lbase+i-1]), 64'd13);
    check("run_done_latency", 64'(done_cyc - start_cyc), 64'd79);
    check("run_epoch_cnt",    64'(epoch_cnt), 64'd2);
    check("run_neuron_in",    64'(neuron_in), DATA_A);
    check("run_target",       64'(target),    64'(TGT_A));
    @(negedge clk);
    check("run_idle_busy",    64'(busy), 64'd0);
    check("run_epoch_hold",   64'(epoch_cnt), 64'd2);

    // ---- Start while busy is ignored ----------------------------------------
    lbase = learn_q.size();
    dbase = n_done;
    do_start(16'd1, 8'd2);
    repeat (5) @(posedge clk);
    #1;
    epochs  = 16'd9;
    samples = 8'd9;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done("busy_done_seen", 200);
    check("busy_learn_count",   64'(learn_q.size() - lbase), 64'd2);
    check("busy_done_latency",  64'(done_cyc - start_cyc),   64'd27);
    check("busy_epoch_cnt",     64'(epoch_cnt),              64'd1);
    repeat (40) @(posedge clk);
    check("busy_single_done",   64'(n_done - dbase),         64'd1);

    // ---- Zero configuration: epochs = 0, then samples = 0 -------------------
    lbase = learn_q.size();
    rbase = n_ready;
    do_start(16'd0, 8'd3);
    wait_done("zero_ep_done_seen", 10);
    check("zero_ep_latency",  64'(done_cyc - start_cyc),   64'd1);
    check("zero_ep_no_ready", 64'(n_ready - rbase),        64'd0);
    check("zero_ep_no_learn", 64'(learn_q.size() - lbase), 64'd0);
    check("zero_ep_epoch",    64'(epoch_cnt),              64'd0);
    do_start(16'd4, 8'd0);
    wait_done("zero_sm_done_seen", 10);
    check("zero_sm_latency",  64'(done_cyc - start_cyc),   64'd1);
    check("zero_sm_no_learn", 64'(learn_q.size() - lbase), 64'd0);

    // ---- Backpressure: source idle for 7 FETCH cycles ------------------------
    s_valid  = 1'b0;
    s_data   = DATA_B;
    s_target = TGT_B;
    lbase = learn_q.size();
    do_start(16'd1, 8'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("bp_s_ready%0d", i),   64'(s_ready),   64'd1);
      check($sformatf("bp_neuron_in%0d", i), 64'(neuron_in), DATA_A);
    end
    check("bp_no_learn", 64'(learn_q.size() - lbase), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b1;
    wait_done("bp_done_seen", 100);
    check("bp_latency",    64'(done_cyc - start_cyc),   64'd21);
    check("bp_learn",      64'(learn_q.size() - lbase), 64'd1);
    check("bp_neuron_in",  64'(neuron_in),              DATA_B);
    check("bp_target",     64'(target),                 64'(TGT_B));

    // ---- Reset asserted mid-SETTLE -------------------------------------------
    dbase = n_done;
    do_start(16'd1, 8'd1);
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",      64'(busy),      64'd0);
    check("mid_done",      64'(done),      64'd0);
    check("mid_s_ready",   64'(s_ready),   64'd0);
    check("mid_learn_en",  64'(learn_en),  64'd0);
    check("mid_neuron_in", 64'(neuron_in), 64'd0);
    check("mid_target",    64'(target),    64'd0);
    check("mid_epoch_cnt", 64'(epoch_cnt), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("mid_no_done",   64'(n_done - dbase), 64'd0);
    check("mid_idle",      64'(busy),           64'd0);

`ifdef TRAINING_SEQUENCER_ERR_ACCUM_EN
    // ---- Error accumulation: |100-40| + |50-40| = 70 -------------------------
    neuron_out = 16'd40;
    s_target   = 16'd100;
    s_valid    = 1'b1;
    lbase = learn_q.size();
    do_start(16'd1, 8'd2);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (learn_q.size() != lbase) break;
    end
    #1;
    s_target = 16'd50;
    wait_done("err_done_seen", 100);
    check("err_sum_at_done", 64'(err_at_done), 64'd70);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
